// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command encodings {cs_n, ras_n, cas_n, we_n},
// default timing parameters and the read-capture state type.
package sdram_pkg;

    localparam logic [3:0] CMD_MRS   = 4'b0000;
    localparam logic [3:0] CMD_AREF  = 4'b0001;
    localparam logic [3:0] CMD_PRE   = 4'b0010;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_READ  = 4'b0101;
    localparam logic [3:0] CMD_NOP   = 4'b0111;

    localparam int CAS_LAT_DEF   = 3;
    localparam int BURST_LEN_DEF = 4;

    typedef enum logic {
        CAP_IDLE = 1'b0,
        CAP_RUN  = 1'b1
    } cap_state_e;

    function automatic logic is_read(input logic [3:0] cmd);
        return cmd == CMD_READ;
    endfunction

endpackage

// File: rtl/sdram_fifo_fwft.sv
// Generic synchronous first-word-fall-through FIFO with sticky overflow.
// Pointers carry one extra wrap bit so full/empty come from the MSB.
module sdram_fifo_fwft #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 5
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              full,
    output logic [CNT_W-1:0]  cnt,
    output logic              overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [CNT_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  rd_ptr;
    logic              pop_ok;
    logic              push_ok;
    logic              drop;

    assign empty = wr_ptr == rd_ptr;
    assign full  = (wr_ptr[CNT_W-1] != rd_ptr[CNT_W-1]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign cnt   = wr_ptr - rd_ptr;

    // A pop frees the slot the same cycle, so push on full+pop is kept.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign drop    = push && full && !pop_ok;

    assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + CNT_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + CNT_W'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdram_rd_capture.sv
// SDRAM read-data capture: snoops READ commands, samples dq after CAS latency
// into an FWFT FIFO. Optional pop-side pattern checker: SDRAM_RD_CHECK_EN.
module sdram_rd_capture
    import sdram_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int CAS_LAT    = CAS_LAT_DEF,
    parameter int BURST_LEN  = BURST_LEN_DEF,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 5
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic [3:0]        sd_cmd,
    input  logic [DATA_W-1:0] sdram_dq_in,
    input  logic              fifo_rd,
    output logic [DATA_W-1:0] fifo_dout,
    output logic              fifo_empty,
    output logic              fifo_full,
    output logic [CNT_W-1:0]  fifo_cnt,
    output logic              overflow,
    output logic              cap_busy
`ifdef SDRAM_RD_CHECK_EN
    ,
    output logic              chk_err,
    output logic [15:0]       chk_err_cnt,
    output logic [DATA_W-1:0] chk_exp
`endif
);

    localparam int BC_W = $clog2(BURST_LEN + 1);

    logic [CAS_LAT-1:0] dly;
    logic               dly_out;
    cap_state_e         state;
    cap_state_e         state_nx;
    logic [BC_W-1:0]    bcnt;
    logic [BC_W-1:0]    bcnt_nx;
    logic               cap_en;
    logic               cap_vld;
    logic [DATA_W-1:0]  cap_data;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            dly <= '0;
        end else if (CAS_LAT > 1) begin
            dly <= {dly[CAS_LAT-2:0], is_read(sd_cmd)};
        end else begin
            dly <= is_read(sd_cmd);
        end
    end

    assign dly_out = dly[CAS_LAT-1];

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= CAP_IDLE;
            bcnt  <= '0;
        end else begin
            state <= state_nx;
            bcnt  <= bcnt_nx;
        end
    end

    // A fresh delay-line pulse always restarts the burst (READ interrupt).
    always_comb begin
        state_nx = state;
        bcnt_nx  = bcnt;
        cap_en   = 1'b0;
        unique case (state)
            CAP_IDLE: begin
                if (dly_out) begin
                    state_nx = CAP_RUN;
                    bcnt_nx  = BC_W'(1);
                    cap_en   = 1'b1;
                end
            end
            CAP_RUN: begin
                if (dly_out) begin
                    bcnt_nx = BC_W'(1);
                    cap_en  = 1'b1;
                end else if (bcnt == BC_W'(BURST_LEN)) begin
                    state_nx = CAP_IDLE;
                    bcnt_nx  = '0;
                end else begin
                    bcnt_nx = bcnt + BC_W'(1);
                    cap_en  = 1'b1;
                end
            end
            default: begin
                state_nx = CAP_IDLE;
                bcnt_nx  = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            cap_vld  <= 1'b0;
            cap_data <= '0;
        end else begin
            cap_vld <= cap_en;
            if (cap_en) begin
                cap_data <= sdram_dq_in;
            end
        end
    end

    assign cap_busy = (|dly) || (state == CAP_RUN);

    sdram_fifo_fwft #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH),
        .CNT_W  (CNT_W)
    ) u_fifo (
        .CLK      (CLK),
        .RSTn     (RSTn),
        .push     (cap_vld),
        .din      (cap_data),
        .pop      (fifo_rd),
        .dout     (fifo_dout),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .cnt      (fifo_cnt),
        .overflow (overflow)
    );

`ifdef SDRAM_RD_CHECK_EN
    logic pop_ok;

    assign pop_ok = fifo_rd && !fifo_empty;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            chk_err     <= 1'b0;
            chk_err_cnt <= '0;
            chk_exp     <= '0;
        end else if (pop_ok) begin
            chk_exp <= chk_exp + DATA_W'(1);
            if (fifo_dout != chk_exp) begin
                chk_err <= 1'b1;
                if (chk_err_cnt != 16'hFFFF) begin
                    chk_err_cnt <= chk_err_cnt + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_sdram_rd_capture.sv
// Randomized + directed bench for sdram_rd_capture against a burst-window
// and queue based reference model.
module tb_sdram_rd_capture;
    import sdram_pkg::*;

    localparam int DW    = 16;
    localparam int CL    = 3;
    localparam int BL    = 4;
    localparam int DEPTH = 16;
    localparam int CW    = 5;

    logic          CLK = 1'b0;
    logic          RSTn = 1'b0;
    logic [3:0]    sd_cmd = CMD_NOP;
    logic [DW-1:0] dq = '0;
    logic          fifo_rd = 1'b0;
    logic [DW-1:0] fifo_dout;
    logic          fifo_empty;
    logic          fifo_full;
    logic [CW-1:0] fifo_cnt;
    logic          overflow;
    logic          cap_busy;
`ifdef SDRAM_RD_CHECK_EN
    logic          chk_err;
    logic [15:0]   chk_err_cnt;
    logic [DW-1:0] chk_exp;
`endif

    int total = 0;
    int bad = 0;

    always #5 CLK = ~CLK;

    sdram_rd_capture #(
        .DATA_W     (DW),
        .CAS_LAT    (CL),
        .BURST_LEN  (BL),
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (CW)
    ) dut (
        .CLK         (CLK),
        .RSTn        (RSTn),
        .sd_cmd      (sd_cmd),
        .sdram_dq_in (dq),
        .fifo_rd     (fifo_rd),
        .fifo_dout   (fifo_dout),
        .fifo_empty  (fifo_empty),
        .fifo_full   (fifo_full),
        .fifo_cnt    (fifo_cnt),
        .overflow    (overflow),
        .cap_busy    (cap_busy)
`ifdef SDRAM_RD_CHECK_EN
        ,
        .chk_err     (chk_err),
        .chk_err_cnt (chk_err_cnt),
        .chk_exp     (chk_exp)
`endif
    );

    task automatic check(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a READ at edge k opens a capture window
    // [k+CL, k+CL+BL-1]; a later READ replaces the window. Captured
    // beats enter a queue one edge later.
    int            ecount = 0;
    int            rd_q[$];
    int            burst_end = -1;
    logic          pend = 1'b0;
    logic [DW-1:0] pend_v = '0;
    logic [DW-1:0] mq[$];
    logic          m_ovf = 1'b0;
    logic          m_busy = 1'b0;
    logic [DW-1:0] m_exp = '0;
    logic          m_err = 1'b0;
    logic [15:0]   m_ecnt = '0;

    always @(posedge CLK) begin
        if (!RSTn) begin
            ecount = 0;
            rd_q.delete();
            burst_end = -1;
            pend = 1'b0;
            mq.delete();
            m_ovf = 1'b0;
            m_busy = 1'b0;
            m_exp = '0;
            m_err = 1'b0;
            m_ecnt = '0;
        end else begin
            if (fifo_rd && mq.size() > 0) begin
                if (mq[0] != m_exp) begin
                    m_err = 1'b1;
                    if (m_ecnt != 16'hFFFF) m_ecnt = m_ecnt + 1;
                end
                m_exp = m_exp + 1;
                void'(mq.pop_front());
            end
            if (pend) begin
                if (mq.size() < DEPTH) mq.push_back(pend_v);
                else m_ovf = 1'b1;
            end
            if (rd_q.size() > 0 && rd_q[0] == ecount - CL) begin
                void'(rd_q.pop_front());
                burst_end = ecount + BL - 1;
            end
            pend = (ecount <= burst_end);
            pend_v = dq;
            if (sd_cmd == CMD_READ) rd_q.push_back(ecount);
            m_busy = (rd_q.size() > 0) || (ecount <= burst_end);
            ecount++;
        end
    end

    always @(negedge CLK) begin
        check("empty", fifo_empty, mq.size() == 0);
        check("full", fifo_full, mq.size() == DEPTH);
        check("cnt", fifo_cnt, mq.size());
        check("overflow", overflow, m_ovf);
        check("busy", cap_busy, m_busy);
        if (mq.size() > 0) check("dout", fifo_dout, mq[0]);
`ifdef SDRAM_RD_CHECK_EN
        check("chk_err", chk_err, m_err);
        check("chk_err_cnt", chk_err_cnt, m_ecnt);
        check("chk_exp", chk_exp, m_exp);
`endif
    end

    task automatic tick(input logic [3:0] c, input logic [DW-1:0] d, input logic r);
        sd_cmd = c;
        dq = d;
        fifo_rd = r;
        @(negedge CLK);
        #1;
    endtask

    task automatic single_read(input logic [DW-1:0] base);
        tick(CMD_READ, 16'h1111, 1'b0);
        tick(CMD_NOP, 16'h2222, 1'b0);
        tick(CMD_NOP, 16'h3333, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(CMD_NOP, base + DW'(i), 1'b0);
            if (i == 0) check("sr_empty_before", fifo_empty, 1);
            if (i == 1) check("sr_empty_after", fifo_empty, 0);
        end
        tick(CMD_NOP, 16'h0, 1'b0);
        check("sr_cnt", fifo_cnt, 4);
        for (int i = 0; i < 4; i++) begin
            check("sr_pop", fifo_dout, base + DW'(i));
            tick(CMD_NOP, 16'h0, 1'b1);
        end
        check("sr_drained", fifo_empty, 1);
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        #1;
        check("rst_empty", fifo_empty, 1);
        check("rst_cnt", fifo_cnt, 0);
        check("rst_busy", cap_busy, 0);
        check("rst_dout", fifo_dout, 0);
        RSTn = 1'b1;
        tick(CMD_NOP, 16'h0, 1'b0);

        single_read(16'hA000);

        for (int t = 0; t < 12; t++) begin
            tick((t == 0 || t == 4) ? CMD_READ : CMD_NOP,
                 (t >= 3) ? DW'(t - 3) : 16'hDEAD, 1'b0);
            if (t == 0) check("b2b_busy_first", cap_busy, 1);
            if (t == 10) check("b2b_busy_last", cap_busy, 1);
            if (t == 11) check("b2b_busy_done", cap_busy, 0);
        end
        check("b2b_cnt", fifo_cnt, 8);
        for (int i = 0; i < 8; i++) begin
            check("b2b_pop", fifo_dout, i);
            tick(CMD_NOP, 16'h0, 1'b1);
        end

        for (int t = 0; t < 11; t++) begin
            tick((t == 0 || t == 2) ? CMD_READ : CMD_NOP, 16'h0100 + DW'(t), 1'b0);
        end
        check("intr_cnt", fifo_cnt, 6);
        for (int i = 0; i < 6; i++) begin
            check("intr_pop", fifo_dout, 16'h0103 + DW'(i));
            tick(CMD_NOP, 16'h0, 1'b1);
        end

        for (int t = 0; t < 24; t++) begin
            tick((t % 4 == 0 && t <= 16) ? CMD_READ : CMD_NOP, 16'h0200 + DW'(t), 1'b0);
        end
        check("ovf_full", fifo_full, 1);
        check("ovf_cnt", fifo_cnt, 16);
        check("ovf_flag", overflow, 1);
        check("ovf_head", fifo_dout, 16'h0203);
        tick(CMD_NOP, 16'h0, 1'b1);
        check("ovf_hold", overflow, 1);
        check("ovf_next", fifo_dout, 16'h0204);
        for (int i = 0; i < 15; i++) tick(CMD_NOP, 16'h0, 1'b1);
        check("ovf_drained", fifo_empty, 1);

        tick(CMD_READ, 16'h0300, 1'b0);
        for (int t = 1; t <= 4; t++) tick(CMD_NOP, 16'h0300 + DW'(t), 1'b0);
        check("mid_cnt", fifo_cnt, 1);
        RSTn = 1'b0;
        #1;
        check("mid_rst_empty", fifo_empty, 1);
        check("mid_rst_cnt", fifo_cnt, 0);
        check("mid_rst_busy", cap_busy, 0);
        check("mid_rst_ovf", overflow, 0);
        check("mid_rst_full", fifo_full, 0);
        check("mid_rst_dout", fifo_dout, 0);
        tick(CMD_READ, 16'h0, 1'b0);
        tick(CMD_NOP, 16'h0, 1'b0);
        RSTn = 1'b1;
        for (int i = 0; i < 6; i++) tick(CMD_NOP, 16'h5555, 1'b0);
        check("post_rst_empty", fifo_empty, 1);
        single_read(16'h0400);

`ifdef SDRAM_RD_CHECK_EN
        RSTn = 1'b0;
        tick(CMD_NOP, 16'h0, 1'b0);
        RSTn = 1'b1;
        for (int t = 0; t < 20; t++) begin
            tick((t % 4 == 0 && t < 16) ? CMD_READ : CMD_NOP,
                 (t == 10) ? 16'hFFFF : DW'(t - 3), 1'b0);
        end
        for (int i = 0; i < 16; i++) begin
            tick(CMD_NOP, 16'h0, 1'b1);
            if (i == 6) check("chk_err_pre", chk_err, 0);
            if (i == 7) check("chk_err_8th", chk_err, 1);
        end
        check("chk_cnt_end", chk_err_cnt, 1);
        check("chk_exp_end", chk_exp, 16);
`endif

        for (int seg = 0; seg < 6; seg++) begin
            int prd;
            int ppop;
            prd = (seg % 3 == 0) ? 30 : 12;
            ppop = (seg % 2 == 0) ? 20 : 70;
            for (int n = 0; n < 500; n++) begin
                logic [3:0] c;
                c = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 99) < prd) c = CMD_READ;
                else if (c == CMD_READ) c = CMD_NOP;
                RSTn = ($urandom_range(0, 399) != 0);
                tick(c, 16'($urandom), ($urandom_range(0, 99) < ppop));
            end
        end
        RSTn = 1'b1;
        tick(CMD_NOP, 16'h0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
